dmem_port_arbiter: RTL and testbench

- Shares the single data/instruction memory port between two requesters.
- Requester "cpu" is the load/store stage. It presents a word address, byte write enables and pre-aligned store data, as produced by the store-alignment logic.
- Requester "aux" is a secondary master, such as the UART program loader or debug.
- The block grants one access per cycle, drives the memory port, and returns registered read data to the requester that issued the read.
- CPU has fixed priority, with a starvation guard for aux and a lock mode for aux bursts.

---
 rtl/dmem_port_arbiter_pkg.sv | 29 ++
 rtl/dmem_port_arbiter_if.sv | 49 ++++
 rtl/dmem_resp_tracker.sv | 36 +++
 rtl/dmem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// State encoding, requester indices and small helpers used by the top and the response tracker.
package dmem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_CPU    = 2'd0,
      AUX_FORCE  = 2'd1,
      AUX_LOCKED = 2'd2
   } arb_state_t;

   localparam logic [3:0] WE_NONE = 4'b0000;
   localparam int         CNT_W   = 4;
   localparam int         DATA_W  = 32;
   localparam int         N_REQ   = 2;
   localparam int         REQ_CPU = 0;
   localparam int         REQ_AUX = 1;

   typedef logic [CNT_W-1:0] starve_cnt_t;

   // An all-zero byte-enable pattern is a read, whatever the requester intended.
   function automatic logic is_read(input logic [3:0] we);
      return we == WE_NONE;
   endfunction

   function automatic starve_cnt_t starve_inc(input starve_cnt_t cnt, input starve_cnt_t limit);
      return (cnt >= limit) ? limit : starve_cnt_t'(cnt + 1'b1);
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both requester handshakes plus the shared memory port.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface dmem_port_arbiter_if
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 12
);

   logic              cpu_req_valid;
   logic              cpu_req_ready;
   logic [ADDR_W-1:0] cpu_req_addr;
   logic [3:0]        cpu_req_we;
   logic [DATA_W-1:0] cpu_req_wdata;
   logic              cpu_resp_valid;
   logic [DATA_W-1:0] cpu_resp_rdata;

   logic              aux_req_valid;
   logic              aux_req_ready;
   logic [ADDR_W-1:0] aux_req_addr;
   logic [3:0]        aux_req_we;
   logic [DATA_W-1:0] aux_req_wdata;
   logic              aux_resp_valid;
   logic [DATA_W-1:0] aux_resp_rdata;
   logic              aux_lock;

   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_we;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport master (
      output cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata,
      output aux_req_valid, aux_req_addr, aux_req_we, aux_req_wdata, aux_lock,
      output mem_dout,
      input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
      input  aux_req_ready, aux_resp_valid, aux_resp_rdata,
      input  mem_addr, mem_we, mem_din
   );

   modport slave (
      input  cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata,
      input  aux_req_valid, aux_req_addr, aux_req_we, aux_req_wdata, aux_lock,
      input  mem_dout,
      output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
      output aux_req_ready, aux_resp_valid, aux_resp_rdata,
      output mem_addr, mem_we, mem_din
   );

endinterface

// File: rtl/dmem_resp_tracker.sv
// Per-requester one-cycle read-response flags; steers mem_dout to whoever issued the read.
// Responses are suppressed while reset is held so an in-flight read never surfaces.
module dmem_resp_tracker
   import dmem_port_arbiter_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             accept_read,
   input  logic [DATA_W-1:0]            mem_dout,
   output logic [N_REQ-1:0]             resp_valid,
   output logic [N_REQ-1:0][DATA_W-1:0] resp_rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         logic pend_reg;
         logic pend_next;

         // A fresh accept simply overwrites the flag, so back-to-back reads chain.
         assign pend_next = accept_read[gi];

         always_ff @(posedge clk) begin
            if (!rst) begin
               pend_reg <= 1'b0;
            end else begin
               pend_reg <= pend_next;
            end
         end

         assign resp_valid[gi] = pend_reg & rst;
         assign resp_rdata[gi] = resp_valid[gi] ? mem_dout : '0;
      end
   endgenerate

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the shared data/instruction memory port.
// CPU has fixed priority; aux gets a starvation guard and an exclusive lock mode for bursts.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int          ADDR_W     = 12
)(
   input  logic               clk,
   input  logic               rst,
   dmem_port_arbiter_if.slave bus
);

   localparam starve_cnt_t STARVE_LIMIT = starve_cnt_t'(STARVE_MAX);

   arb_state_t  state_reg, state_next;
   starve_cnt_t cnt_reg, cnt_next;

   logic              cpu_ready;
   logic              aux_ready;
   logic              cpu_grant;
   logic              aux_grant;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] din_sel;
   logic [3:0]        we_sel;

   logic [N_REQ-1:0]             accept_read;
   logic [N_REQ-1:0]             resp_valid;
   logic [N_REQ-1:0][DATA_W-1:0] resp_rdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ARB_CPU;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cpu_ready  = 1'b0;
      aux_ready  = 1'b0;

      case (state_reg)
         ARB_CPU: begin
            // A saturated counter normally means we already left for AUX_FORCE;
            // honouring it here keeps the guard intact even if that edge was missed.
            if (bus.aux_req_valid && (cnt_reg >= STARVE_LIMIT)) begin
               aux_ready = 1'b1;
            end else if (bus.cpu_req_valid) begin
               cpu_ready = 1'b1;
            end else if (bus.aux_req_valid) begin
               aux_ready = 1'b1;
            end

            if (aux_ready) begin
               cnt_next = '0;
               if (bus.aux_lock) begin
                  state_next = AUX_LOCKED;
               end
            end else if (bus.aux_req_valid) begin
               cnt_next = starve_inc(cnt_reg, STARVE_LIMIT);
               if (cnt_next == STARVE_LIMIT) begin
                  state_next = AUX_FORCE;
               end
            end
         end

         AUX_FORCE: begin
            aux_ready  = bus.aux_req_valid;
            cnt_next   = '0;
            state_next = (bus.aux_req_valid && bus.aux_lock) ? AUX_LOCKED : ARB_CPU;
         end

         AUX_LOCKED: begin
            // The cycle in which lock drops is still aux's; cpu regains the port after the edge.
            aux_ready = bus.aux_req_valid;
            cnt_next  = '0;
            if (!bus.aux_lock) begin
               state_next = ARB_CPU;
            end
         end

         default: begin
            state_next = ARB_CPU;
            cnt_next   = '0;
         end
      endcase

      if (!rst) begin
         cpu_ready = 1'b0;
         aux_ready = 1'b0;
      end
   end

   assign cpu_grant = bus.cpu_req_valid & cpu_ready;
   assign aux_grant = bus.aux_req_valid & aux_ready;

   // With no grant the address/data buses idle on the cpu inputs; only we is forced quiet.
   always_comb begin
      addr_sel = bus.cpu_req_addr;
      din_sel  = bus.cpu_req_wdata;
      we_sel   = WE_NONE;
      if (aux_grant) begin
         addr_sel = bus.aux_req_addr;
         din_sel  = bus.aux_req_wdata;
         we_sel   = bus.aux_req_we;
      end else if (cpu_grant) begin
         we_sel   = bus.cpu_req_we;
      end
   end

   assign bus.mem_addr      = addr_sel;
   assign bus.mem_din       = din_sel;
   assign bus.mem_we        = we_sel;
   assign bus.cpu_req_ready = cpu_ready;
   assign bus.aux_req_ready = aux_ready;

   assign accept_read[REQ_CPU] = cpu_grant & is_read(bus.cpu_req_we);
   assign accept_read[REQ_AUX] = aux_grant & is_read(bus.aux_req_we);

   dmem_resp_tracker u_resp_tracker (
      .clk         (clk),
      .rst         (rst),
      .accept_read (accept_read),
      .mem_dout    (bus.mem_dout),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata)
   );

   assign bus.cpu_resp_valid = resp_valid[REQ_CPU];
   assign bus.cpu_resp_rdata = resp_rdata[REQ_CPU];
   assign bus.aux_resp_valid = resp_valid[REQ_AUX];
   assign bus.aux_resp_rdata = resp_rdata[REQ_AUX];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: reset, reads, starvation guard, lock bursts, back-to-back reads.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_port_arbiter;
   import dmem_port_arbiter_pkg::*;

   localparam int ADDR_W     = 12;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   dmem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

   dmem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_addr  = '0;
      bus.cpu_req_we    = 4'h0;
      bus.cpu_req_wdata = '0;
      bus.aux_req_valid = 1'b0;
      bus.aux_req_addr  = '0;
      bus.aux_req_we    = 4'h0;
      bus.aux_req_wdata = '0;
      bus.aux_lock      = 1'b0;
      bus.mem_dout      = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_addr  = 12'h0AB;
      bus.cpu_req_we    = 4'hF;
      bus.cpu_req_wdata = 32'h0102_0304;
      bus.aux_req_valid = 1'b1;
      bus.aux_req_addr  = 12'h0CD;
      bus.aux_req_we    = 4'hF;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++; if (bus.cpu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready[%0d]: got %b want 0", i, bus.cpu_req_ready); end
         checks++; if (bus.aux_req_ready !== 1'b0) begin errors++; $display("FAIL reset_aux_ready[%0d]: got %b want 0", i, bus.aux_req_ready); end
         checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL reset_mem_we[%0d]: got %h want 0", i, bus.mem_we); end
         checks++; if ({bus.cpu_resp_valid, bus.aux_resp_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid[%0d]: got %b want 00", i, {bus.cpu_resp_valid, bus.aux_resp_valid}); end
         next_cycle();
      end
      rst = 1'b1;
      sample();
      checks++; if (bus.cpu_req_ready !== 1'b1) begin errors++; $display("FAIL release_cpu_ready: got %b want 1", bus.cpu_req_ready); end
      checks++; if (bus.aux_req_ready !== 1'b0) begin errors++; $display("FAIL release_aux_ready: got %b want 0", bus.aux_req_ready); end
      checks++; if (bus.mem_we !== 4'hF) begin errors++; $display("FAIL release_mem_we: got %h want f", bus.mem_we); end
      checks++; if (bus.mem_addr !== 12'h0AB) begin errors++; $display("FAIL release_mem_addr: got %h want 0ab", bus.mem_addr); end
      next_cycle();
      $display("test_reset: done");
   endtask

   task automatic test_cpu_read();
      do_reset();
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_addr  = 12'h010;
      bus.cpu_req_we    = 4'h0;
      sample();
      checks++; if (bus.cpu_req_ready !== 1'b1) begin errors++; $display("FAIL cpu_read_ready: got %b want 1", bus.cpu_req_ready); end
      checks++; if (bus.mem_addr !== 12'h010) begin errors++; $display("FAIL cpu_read_addr: got %h want 010", bus.mem_addr); end
      checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL cpu_read_we: got %h want 0", bus.mem_we); end
      next_cycle();
      bus.cpu_req_valid = 1'b0;
      bus.mem_dout      = 32'hDEAD_BEEF;
      sample();
      checks++; if (bus.cpu_resp_valid !== 1'b1) begin errors++; $display("FAIL cpu_read_resp_valid: got %b want 1", bus.cpu_resp_valid); end
      checks++; if (bus.cpu_resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cpu_read_rdata: got %h want deadbeef", bus.cpu_resp_rdata); end
      checks++; if (bus.aux_resp_valid !== 1'b0) begin errors++; $display("FAIL cpu_read_aux_resp: got %b want 0", bus.aux_resp_valid); end
      next_cycle();
      sample();
      checks++; if (bus.cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL cpu_read_one_pulse: got %b want 0", bus.cpu_resp_valid); end
      checks++; if (bus.cpu_resp_rdata !== 32'h0) begin errors++; $display("FAIL cpu_read_rdata_idle: got %h want 0", bus.cpu_resp_rdata); end
      next_cycle();
      $display("test_cpu_read: done");
   endtask

   task automatic test_starvation();
      logic        exp_aux;
      logic [3:0]  exp_we;
      logic [11:0] exp_addr;
      logic [31:0] exp_din;
      do_reset();
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_addr  = 12'h100;
      bus.cpu_req_we    = 4'b0011;
      bus.cpu_req_wdata = 32'h0000_BEEF;
      bus.aux_req_valid = 1'b1;
      bus.aux_req_addr  = 12'h200;
      bus.aux_req_we    = 4'hF;
      bus.aux_req_wdata = 32'hA5A5_A5A5;
      for (int k = 0; k < 2 * (STARVE_MAX + 1); k++) begin
         exp_aux  = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
         exp_we   = exp_aux ? 4'hF : 4'b0011;
         exp_addr = exp_aux ? 12'h200 : 12'h100;
         exp_din  = exp_aux ? 32'hA5A5_A5A5 : 32'h0000_BEEF;
         sample();
         checks++; if (bus.cpu_req_ready !== !exp_aux) begin errors++; $display("FAIL starve_cpu_ready[%0d]: got %b want %b", k, bus.cpu_req_ready, !exp_aux); end
         checks++; if (bus.aux_req_ready !== exp_aux) begin errors++; $display("FAIL starve_aux_ready[%0d]: got %b want %b", k, bus.aux_req_ready, exp_aux); end
         checks++; if (bus.mem_we !== exp_we) begin errors++; $display("FAIL starve_mem_we[%0d]: got %h want %h", k, bus.mem_we, exp_we); end
         checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL starve_mem_addr[%0d]: got %h want %h", k, bus.mem_addr, exp_addr); end
         checks++; if (bus.mem_din !== exp_din) begin errors++; $display("FAIL starve_mem_din[%0d]: got %h want %h", k, bus.mem_din, exp_din); end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
      $display("test_starvation: done");
   endtask

   task automatic test_lock();
      logic [11:0] exp_addr;
      do_reset();
      bus.aux_req_valid = 1'b1;
      bus.aux_lock      = 1'b1;
      bus.aux_req_addr  = 12'h300;
      bus.aux_req_we    = 4'h0;
      sample();
      checks++; if (bus.aux_req_ready !== 1'b1) begin errors++; $display("FAIL lock_first_aux_ready: got %b want 1", bus.aux_req_ready); end
      checks++; if (bus.mem_addr !== 12'h300) begin errors++; $display("FAIL lock_first_addr: got %h want 300", bus.mem_addr); end
      next_cycle();
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_addr  = 12'h050;
      bus.cpu_req_we    = 4'h0;
      bus.aux_req_we    = 4'hF;
      bus.mem_dout      = 32'hCAFE_F00D;
      for (int i = 0; i < 6; i++) begin
         exp_addr = 12'h301 + 12'(i);
         bus.aux_req_addr  = exp_addr;
         bus.aux_req_wdata = 32'h1000_0000 + 32'(i);
         sample();
         if (i == 0) begin
            checks++; if (bus.aux_resp_valid !== 1'b1) begin errors++; $display("FAIL lock_aux_resp_valid: got %b want 1", bus.aux_resp_valid); end
            checks++; if (bus.aux_resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL lock_aux_rdata: got %h want cafef00d", bus.aux_resp_rdata); end
            checks++; if (bus.cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL lock_cpu_resp: got %b want 0", bus.cpu_resp_valid); end
         end else begin
            checks++; if (bus.aux_resp_valid !== 1'b0) begin errors++; $display("FAIL lock_write_no_resp[%0d]: got %b want 0", i, bus.aux_resp_valid); end
         end
         checks++; if (bus.cpu_req_ready !== 1'b0) begin errors++; $display("FAIL lock_cpu_ready[%0d]: got %b want 0", i, bus.cpu_req_ready); end
         checks++; if (bus.aux_req_ready !== 1'b1) begin errors++; $display("FAIL lock_aux_ready[%0d]: got %b want 1", i, bus.aux_req_ready); end
         checks++; if (bus.mem_we !== 4'hF) begin errors++; $display("FAIL lock_mem_we[%0d]: got %h want f", i, bus.mem_we); end
         checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL lock_mem_addr[%0d]: got %h want %h", i, bus.mem_addr, exp_addr); end
         next_cycle();
      end
      bus.aux_lock     = 1'b0;
      bus.aux_req_addr = 12'h307;
      sample();
      checks++; if (bus.aux_req_ready !== 1'b1) begin errors++; $display("FAIL unlock_cycle_aux_ready: got %b want 1", bus.aux_req_ready); end
      checks++; if (bus.cpu_req_ready !== 1'b0) begin errors++; $display("FAIL unlock_cycle_cpu_ready: got %b want 0", bus.cpu_req_ready); end
      checks++; if (bus.mem_addr !== 12'h307) begin errors++; $display("FAIL unlock_cycle_addr: got %h want 307", bus.mem_addr); end
      next_cycle();
      sample();
      checks++; if (bus.cpu_req_ready !== 1'b1) begin errors++; $display("FAIL after_unlock_cpu_ready: got %b want 1", bus.cpu_req_ready); end
      checks++; if (bus.aux_req_ready !== 1'b0) begin errors++; $display("FAIL after_unlock_aux_ready: got %b want 0", bus.aux_req_ready); end
      checks++; if (bus.mem_addr !== 12'h050) begin errors++; $display("FAIL after_unlock_addr: got %h want 050", bus.mem_addr); end
      checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL after_unlock_we: got %h want 0", bus.mem_we); end
      next_cycle();
      idle_inputs();
      next_cycle();
      $display("test_lock: done");
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      bus.aux_req_valid = 1'b1;
      bus.aux_req_addr  = 12'h0AA;
      bus.aux_req_we    = 4'h0;
      sample();
      checks++; if (bus.aux_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_accept: got %b want 1", bus.aux_req_ready); end
      next_cycle();
      rst = 1'b0;
      bus.aux_req_valid = 1'b0;
      bus.mem_dout      = 32'h1234_5678;
      sample();
      checks++; if (bus.aux_resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_resp_in_reset: got %b want 0", bus.aux_resp_valid); end
      checks++; if (bus.aux_resp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata_in_reset: got %h want 0", bus.aux_resp_rdata); end
      next_cycle();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sample();
         checks++; if ({bus.cpu_resp_valid, bus.aux_resp_valid} !== 2'b00) begin errors++; $display("FAIL midrst_stale_resp[%0d]: got %b want 00", i, {bus.cpu_resp_valid, bus.aux_resp_valid}); end
         next_cycle();
      end
      $display("test_reset_mid_read: done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] dout_tab [4];
      dout_tab[0] = 32'h1111_1111;
      dout_tab[1] = 32'h2222_2222;
      dout_tab[2] = 32'h3333_3333;
      dout_tab[3] = 32'h4444_4444;
      do_reset();
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_we    = 4'h0;
      for (int i = 0; i < 5; i++) begin
         bus.cpu_req_valid = (i < 3);
         bus.cpu_req_addr  = 12'(i + 1);
         bus.mem_dout      = (i > 0) ? dout_tab[i-1] : 32'h0;
         sample();
         if (i < 3) begin
            checks++; if (bus.mem_addr !== 12'(i + 1)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, bus.mem_addr, 12'(i + 1)); end
         end
         if (i >= 1 && i <= 3) begin
            checks++; if (bus.cpu_resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_resp_valid[%0d]: got %b want 1", i, bus.cpu_resp_valid); end
            checks++; if (bus.cpu_resp_rdata !== dout_tab[i-1]) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, bus.cpu_resp_rdata, dout_tab[i-1]); end
         end else begin
            checks++; if (bus.cpu_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_resp[%0d]: got %b want 0", i, bus.cpu_resp_valid); end
         end
         next_cycle();
      end
      idle_inputs();
      $display("test_back_to_back: done");
   endtask

   initial begin
      idle_inputs();
      next_cycle();
      test_reset();
      test_cpu_read();
      test_starvation();
      test_lock();
      test_reset_mid_read();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
